// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// Launches one byte per frame, tracks Tx_busy, enforces an idle gap and a launch watchdog.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         Req,
    input  logic [NUM_REQ*DATA_W-1:0]  Req_data,
    output logic [NUM_REQ-1:0]         Ack,
    output logic [DATA_W-1:0]          Tx_data,
    output logic                       Tx_valid,
    input  logic                       Tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] Grant_id,
    output logic                       Arb_busy,
    input  logic                       Err_clr,
    output logic                       Err_flag
);

    localparam int unsigned PTR_W   = $clog2(NUM_REQ);
    localparam int unsigned CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    // Where a finished or aborted frame goes; with no gap configured it returns straight to IDLE.
    localparam state_t POST_ST   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
    localparam logic   POST_BUSY = (GAP_CYCLES != 0);

    state_t             r_state;
    logic [NUM_REQ-1:0] r_ack;
    logic [DATA_W-1:0]  r_tx_data;
    logic               r_tx_valid;
    logic [PTR_W-1:0]   r_grant;
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_arb_busy;
    logic               r_err;

    logic               w_found;
    logic [PTR_W-1:0]   w_win;
    logic [DATA_W-1:0]  w_data;

    // Rotating priority: first pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_data  = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!w_found && Req[j] && (j >= 32'(r_ptr))) begin
                w_found = 1'b1;
                w_win   = PTR_W'(j);
                w_data  = Req_data[j*DATA_W +: DATA_W];
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!w_found && Req[j] && (j < 32'(r_ptr))) begin
                w_found = 1'b1;
                w_win   = PTR_W'(j);
                w_data  = Req_data[j*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_ack      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_arb_busy <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ack      <= '0;
            r_tx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A busy transmitter here belongs to someone else; hold off until it frees.
                    if (w_found && !Tx_busy) begin
                        r_grant    <= w_win;
                        r_tx_data  <= w_data;
                        r_ack      <= NUM_REQ'(1) << w_win;
                        r_tx_valid <= 1'b1;
                        r_arb_busy <= 1'b1;
                        r_state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_ptr   <= (r_grant == PTR_W'(NUM_REQ - 1)) ? '0 : r_grant + PTR_W'(1);
                    r_cnt   <= '0;
                    r_state <= Tx_busy ? S_WAIT_DONE : S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (Tx_busy) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == TO_LAST) begin
                        r_err      <= 1'b1;
                        r_cnt      <= '0;
                        r_arb_busy <= POST_BUSY;
                        r_state    <= POST_ST;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!Tx_busy) begin
                        r_cnt      <= '0;
                        r_arb_busy <= POST_BUSY;
                        r_state    <= POST_ST;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt      <= '0;
                        r_arb_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt      <= '0;
                    r_arb_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
            if (Err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign Ack      = r_ack;
    assign Tx_data  = r_tx_data;
    assign Tx_valid = r_tx_valid;
    assign Grant_id = r_grant;
    assign Arb_busy = r_arb_busy;
    assign Err_flag = r_err;

endmodule
